spi_txn_scheduler: RTL and testbench

//  Shares the single SPI transaction engine between NUM_REQ command-port requesters (e.g. AES key fetch, SHA block fetch).

---
 rtl/spi_mem_pkg.sv | 20 ++
 rtl/spi_txn_scheduler_rr_arbiter.sv | 35 +++
 rtl/spi_txn_scheduler.sv | 164 ++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI transaction scheduler: FSM state
// encoding, default field widths and completion error codes.
package spi_mem_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer,
// wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr+i cannot overflow before the wrap.
            w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!o_any && i_valid[w_cand[IDX_W-1:0]]) begin
                o_any                       = 1'b1;
                o_grant[w_cand[IDX_W-1:0]]  = 1'b1;
                o_idx                       = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI transaction engine among NUM_REQ command ports (round-robin).
// Optional WAIT-state watchdog enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_txn_scheduler
    import spi_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*8-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]        req_wtake,
    output logic [7:0]                req_rdata,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic                      rsp_err,
    output logic                      txn_start,
    output logic                      txn_rw,
    output logic [ADDR_W-1:0]         txn_addr,
    output logic [LEN_W-1:0]          txn_len,
    output logic                      txn_abort,
    input  logic                      txn_busy,
    input  logic                      txn_done,
    input  logic                      txn_wtake,
    output logic [7:0]                txn_wdata,
    input  logic [7:0]                txn_rdata,
    input  logic                      txn_rvalid,
    output logic [2:0]                dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e         r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_onehot;
    logic                 r_rw;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;
    logic [1:0]           r_err_code;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_timeout;

    logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
    logic [LEN_W-1:0]     w_len   [NUM_REQ];
    logic [7:0]           w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_len[g]   = req_len[g*LEN_W +: LEN_W];
        assign w_wdata[g] = req_wdata[g*8 +: 8];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counter holds the number of WAIT cycles already elapsed.
    assign w_timeout = (r_state == ST_WAIT) && !txn_done &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_onehot   <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_idx;
                        r_onehot   <= w_grant;
                        r_rw       <= req_rw[w_idx];
                        r_addr     <= w_addr[w_idx];
                        r_len      <= w_len[w_idx];
                        r_err_code <= ERR_NONE;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (r_len == '0) begin
                        r_err_code <= ERR_ZERO_LEN;
                        r_state    <= ST_DONE;
                    end else begin
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!txn_busy) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (txn_done) begin
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state, so they drop to 0 on reset.
    assign req_ready  = (r_state == ST_GRANT) ? r_onehot : '0;
    assign txn_start  = (r_state == ST_ISSUE) && !txn_busy;
    assign req_wtake  = (r_state == ST_WAIT && txn_wtake)  ? r_onehot : '0;
    assign req_rvalid = (r_state == ST_WAIT && txn_rvalid) ? r_onehot : '0;
    assign req_rdata  = (r_state == ST_WAIT) ? txn_rdata : 8'h00;
    assign rsp_done   = (r_state == ST_DONE) ? r_onehot : '0;
    assign rsp_err    = (r_state == ST_DONE) && (r_err_code != ERR_NONE);
    assign txn_abort  = w_timeout;
    assign txn_rw     = r_rw;
    assign txn_addr   = r_addr;
    assign txn_len    = r_len;
    assign txn_wdata  = (r_state == ST_IDLE) ? 8'h00 : w_wdata[r_owner];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler (NUM_REQ=2, TIMEOUT=16); the timeout
// scenario follows SPI_SCHED_TIMEOUT_EN just like the design.
module tb_spi_txn_scheduler;

    localparam int NR = 2;
    localparam int AW = 24;
    localparam int LW = 8;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]   req_ready;
    logic [NR*8-1:0] req_wdata;
    logic [NR-1:0]   req_wtake;
    logic [7:0]      req_rdata;
    logic [NR-1:0]   req_rvalid;
    logic [NR-1:0]   rsp_done;
    logic            rsp_err;
    logic            txn_start;
    logic            txn_rw;
    logic [AW-1:0]   txn_addr;
    logic [LW-1:0]   txn_len;
    logic            txn_abort;
    logic            txn_busy;
    logic            txn_done;
    logic            txn_wtake;
    logic [7:0]      txn_wdata;
    logic [7:0]      txn_rdata;
    logic            txn_rvalid;
    logic [2:0]      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    spi_txn_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .req_wdata  (req_wdata),
        .req_wtake  (req_wtake),
        .req_rdata  (req_rdata),
        .req_rvalid (req_rvalid),
        .rsp_done   (rsp_done),
        .rsp_err    (rsp_err),
        .txn_start  (txn_start),
        .txn_rw     (txn_rw),
        .txn_addr   (txn_addr),
        .txn_len    (txn_len),
        .txn_abort  (txn_abort),
        .txn_busy   (txn_busy),
        .txn_done   (txn_done),
        .txn_wtake  (txn_wtake),
        .txn_wdata  (txn_wdata),
        .txn_rdata  (txn_rdata),
        .txn_rvalid (txn_rvalid),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        txn_busy   = 1'b0;
        txn_done   = 1'b0;
        txn_wtake  = 1'b0;
        txn_rdata  = 8'h00;
        txn_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Called right after the GRANT-cycle sample; returns sampled in the DONE cycle.
    task automatic run_txn(input logic [NR-1:0] drop);
        next(); req_valid = req_valid & ~drop; mid();
        next(); txn_done = 1'b1; mid();
        next(); txn_done = 1'b0; mid();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [63:0] outs;
        rst = 1'b0;
        clear_inputs();
        req_valid = 2'b11;
        req_len   = {8'd3, 8'd3};
        repeat (3) @(posedge clk);
        mid();
        outs = {req_ready, req_wtake, req_rdata, req_rvalid, rsp_done, rsp_err, txn_start,
                txn_rw, txn_addr, txn_len, txn_abort, txn_wdata, dbg_state};
        n_cmp++;
        if (outs !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        clear_inputs();
        next();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        logic [7:0] exp_b;
        next();
        req_valid = 2'b01; req_rw = 2'b00;
        req_addr  = {24'h0, 24'h001000};
        req_len   = {8'd0, 8'd4};
        mid();
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL read_idle_ready: got %b expected 00", req_ready); end
        next(); mid();
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL read_ready_c1: got %b expected 01", req_ready); end
        n_cmp++; if (txn_start !== 1'b0) begin n_bad++; $display("FAIL read_nostart_c1: got %b expected 0", txn_start); end
        next(); req_valid = 2'b00; mid();
        n_cmp++; if (txn_start !== 1'b1) begin n_bad++; $display("FAIL read_start_c2: got %b expected 1", txn_start); end
        n_cmp++; if (txn_addr !== 24'h001000) begin n_bad++; $display("FAIL read_addr: got %h expected 001000", txn_addr); end
        n_cmp++; if (txn_len !== 8'd4) begin n_bad++; $display("FAIL read_len: got %0d expected 4", txn_len); end
        n_cmp++; if (txn_rw !== 1'b0) begin n_bad++; $display("FAIL read_rw: got %b expected 0", txn_rw); end
        for (int b = 0; b < 4; b++) begin
            next(); txn_rvalid = 1'b1; txn_rdata = 8'hA0 + 8'(b); mid();
            exp_b = 8'hA0 + 8'(b);
            n_cmp++; if (req_rvalid !== 2'b01) begin n_bad++; $display("FAIL read_rvalid%0d: got %b expected 01", b, req_rvalid); end
            n_cmp++; if (req_rdata !== exp_b) begin n_bad++; $display("FAIL read_rdata%0d: got %h expected %h", b, req_rdata, exp_b); end
        end
        next(); txn_rvalid = 1'b0; txn_done = 1'b1; mid();
        n_cmp++; if (rsp_done !== 2'b00) begin n_bad++; $display("FAIL read_done_early: got %b expected 00", rsp_done); end
        next(); txn_done = 1'b0; mid();
        n_cmp++; if (rsp_done !== 2'b01) begin n_bad++; $display("FAIL read_done: got %b expected 01", rsp_done); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b expected 0", rsp_err); end
        next(); mid();
        n_cmp++; if (rsp_done !== 2'b00) begin n_bad++; $display("FAIL read_done_pulse: got %b expected 00", rsp_done); end
    endtask

    task automatic test_round_robin();
        do_reset();
        next();
        req_valid = 2'b11; req_rw = 2'b00;
        req_addr  = {24'h000200, 24'h000100};
        req_len   = {8'd1, 8'd1};
        mid();
        next(); mid();
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rr_first: got %b expected 01", req_ready); end
        n_cmp++; if (txn_addr !== 24'h000100) begin n_bad++; $display("FAIL rr_first_addr: got %h expected 000100", txn_addr); end
        run_txn(2'b01);
        n_cmp++; if (rsp_done !== 2'b01) begin n_bad++; $display("FAIL rr_first_done: got %b expected 01", rsp_done); end
        req_valid = 2'b11;
        next(); mid();
        next(); mid();
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rr_second: got %b expected 10", req_ready); end
        n_cmp++; if (txn_addr !== 24'h000200) begin n_bad++; $display("FAIL rr_second_addr: got %h expected 000200", txn_addr); end
        run_txn(2'b10);
        n_cmp++; if (rsp_done !== 2'b10) begin n_bad++; $display("FAIL rr_second_done: got %b expected 10", rsp_done); end
        next(); mid();
        next(); mid();
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rr_third: got %b expected 01", req_ready); end
        run_txn(2'b01);
        n_cmp++; if (rsp_done !== 2'b01) begin n_bad++; $display("FAIL rr_third_done: got %b expected 01", rsp_done); end
        next(); mid();
    endtask

    task automatic test_write_routing();
        next();
        req_valid = 2'b10; req_rw = 2'b10;
        req_addr  = {24'h00ABCD, 24'h0};
        req_len   = {8'd2, 8'd0};
        req_wdata = {8'h5A, 8'hC3};
        mid();
        n_cmp++; if (txn_wdata !== 8'h00) begin n_bad++; $display("FAIL wr_wdata_idle: got %h expected 00", txn_wdata); end
        next(); mid();
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL wr_ready: got %b expected 10", req_ready); end
        n_cmp++; if (txn_wdata !== 8'h5A) begin n_bad++; $display("FAIL wr_wdata_mux: got %h expected 5a", txn_wdata); end
        n_cmp++; if (txn_rw !== 1'b1) begin n_bad++; $display("FAIL wr_rw: got %b expected 1", txn_rw); end
        n_cmp++; if (txn_len !== 8'd2) begin n_bad++; $display("FAIL wr_len: got %0d expected 2", txn_len); end
        next(); req_valid = 2'b00; mid();
        n_cmp++; if (txn_start !== 1'b1) begin n_bad++; $display("FAIL wr_start: got %b expected 1", txn_start); end
        next(); txn_wtake = 1'b1; mid();
        n_cmp++; if (req_wtake !== 2'b10) begin n_bad++; $display("FAIL wr_wtake0: got %b expected 10", req_wtake); end
        next(); req_wdata[15:8] = 8'h6B; mid();
        n_cmp++; if (txn_wdata !== 8'h6B) begin n_bad++; $display("FAIL wr_wdata_b1: got %h expected 6b", txn_wdata); end
        n_cmp++; if (req_wtake !== 2'b10) begin n_bad++; $display("FAIL wr_wtake1: got %b expected 10", req_wtake); end
        next(); txn_wtake = 1'b0; txn_done = 1'b1; mid();
        n_cmp++; if (req_wtake !== 2'b00) begin n_bad++; $display("FAIL wr_wtake_idle: got %b expected 00", req_wtake); end
        next(); txn_done = 1'b0; mid();
        n_cmp++; if (rsp_done !== 2'b10) begin n_bad++; $display("FAIL wr_done: got %b expected 10", rsp_done); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", rsp_err); end
        next(); mid();
        n_cmp++; if (txn_wdata !== 8'h00) begin n_bad++; $display("FAIL wr_wdata_after: got %h expected 00", txn_wdata); end
        req_wdata = '0; req_rw = '0;
    endtask

    task automatic test_zero_len();
        logic start_seen;
        start_seen = 1'b0;
        next(); req_valid = 2'b01; req_len = '0; mid();
        start_seen |= txn_start;
        next(); mid();
        start_seen |= txn_start;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL zl_ready: got %b expected 01", req_ready); end
        next(); req_valid = 2'b00; mid();
        start_seen |= txn_start;
        n_cmp++; if (rsp_done !== 2'b01) begin n_bad++; $display("FAIL zl_done: got %b expected 01", rsp_done); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL zl_err: got %b expected 1", rsp_err); end
        for (int i = 0; i < 3; i++) begin
            next(); mid();
            start_seen |= txn_start;
        end
        n_cmp++; if (start_seen !== 1'b0) begin n_bad++; $display("FAIL zl_no_start: got %b expected 0", start_seen); end
        n_cmp++; if (rsp_done !== 2'b00) begin n_bad++; $display("FAIL zl_done_pulse: got %b expected 00", rsp_done); end
    endtask

    task automatic test_busy_hold();
        logic start_bad;
        logic field_bad;
        start_bad = 1'b0;
        field_bad = 1'b0;
        next();
        txn_busy  = 1'b1;
        req_valid = 2'b01;
        req_addr  = {24'h0, 24'hABCDEF};
        req_len   = {8'd0, 8'd3};
        mid();
        next(); mid();
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL busy_ready: got %b expected 01", req_ready); end
        next(); req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            mid();
            start_bad |= txn_start;
            field_bad |= (txn_addr !== 24'hABCDEF) || (txn_len !== 8'd3);
        end
        n_cmp++; if (start_bad !== 1'b0) begin n_bad++; $display("FAIL busy_no_start: got %b expected 0", start_bad); end
        n_cmp++; if (field_bad !== 1'b0) begin n_bad++; $display("FAIL busy_fields: got %b expected 0", field_bad); end
        n_cmp++; if (dbg_state !== 3'd2) begin n_bad++; $display("FAIL busy_state: got %0d expected 2", dbg_state); end
        next(); txn_busy = 1'b0; mid();
        n_cmp++; if (txn_start !== 1'b1) begin n_bad++; $display("FAIL busy_start: got %b expected 1", txn_start); end
        n_cmp++; if (txn_addr !== 24'hABCDEF) begin n_bad++; $display("FAIL busy_addr: got %h expected abcdef", txn_addr); end
        next(); txn_done = 1'b1; mid();
        next(); txn_done = 1'b0; mid();
        n_cmp++; if (rsp_done !== 2'b01) begin n_bad++; $display("FAIL busy_done: got %b expected 01", rsp_done); end
        next(); mid();
    endtask

    task automatic test_timeout();
        logic abort_seen;
        logic done_seen;
        abort_seen = 1'b0;
        done_seen  = 1'b0;
        next(); req_valid = 2'b10; req_addr = {24'h000040, 24'h0}; req_len = {8'd1, 8'd0}; mid();
        next(); mid();
        next(); req_valid = 2'b00; mid();
        n_cmp++; if (txn_start !== 1'b1) begin n_bad++; $display("FAIL to_start: got %b expected 1", txn_start); end
`ifdef SPI_SCHED_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            next(); mid();
            abort_seen |= txn_abort;
            done_seen  |= (rsp_done != '0);
        end
        n_cmp++; if (abort_seen !== 1'b0) begin n_bad++; $display("FAIL to_early_abort: got %b expected 0", abort_seen); end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL to_early_done: got %b expected 0", done_seen); end
        next(); mid();
        n_cmp++; if (txn_abort !== 1'b1) begin n_bad++; $display("FAIL to_abort_w16: got %b expected 1", txn_abort); end
        next(); mid();
        n_cmp++; if (rsp_done !== 2'b10) begin n_bad++; $display("FAIL to_done: got %b expected 10", rsp_done); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b expected 1", rsp_err); end
        n_cmp++; if (txn_abort !== 1'b0) begin n_bad++; $display("FAIL to_abort_pulse: got %b expected 0", txn_abort); end
        next(); mid();
`else
        for (int k = 1; k <= 40; k++) begin
            next(); mid();
            abort_seen |= txn_abort;
            done_seen  |= (rsp_done != '0);
        end
        n_cmp++; if (abort_seen !== 1'b0) begin n_bad++; $display("FAIL nto_abort: got %b expected 0", abort_seen); end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL nto_done: got %b expected 0", done_seen); end
        n_cmp++; if (dbg_state !== 3'd3) begin n_bad++; $display("FAIL nto_state: got %0d expected 3", dbg_state); end
        next(); txn_done = 1'b1; mid();
        next(); txn_done = 1'b0; mid();
        n_cmp++; if (rsp_done !== 2'b10) begin n_bad++; $display("FAIL nto_done_late: got %b expected 10", rsp_done); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL nto_err: got %b expected 0", rsp_err); end
        next(); mid();
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] outs;
        logic        done_seen;
        done_seen = 1'b0;
        next(); req_valid = 2'b01; req_addr = {24'h0, 24'h000800}; req_len = {8'd0, 8'd4}; mid();
        next(); mid();
        next(); req_valid = 2'b00; mid();
        next(); txn_rvalid = 1'b1; txn_rdata = 8'h77; txn_wtake = 1'b1; req_wdata = {8'h11, 8'h22}; mid();
        n_cmp++; if (req_rvalid !== 2'b01) begin n_bad++; $display("FAIL rmw_in_wait: got %b expected 01", req_rvalid); end
        #1 rst = 1'b0;
        #1;
        outs = {req_ready, req_wtake, req_rdata, req_rvalid, rsp_done, rsp_err, txn_start,
                txn_rw, txn_addr, txn_len, txn_abort, txn_wdata, dbg_state};
        n_cmp++; if (outs !== 64'h0) begin n_bad++; $display("FAIL rmw_outputs: got %h expected 0", outs); end
        next(); clear_inputs(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next(); mid();
            done_seen |= (rsp_done != '0);
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL rmw_no_done: got %b expected 0", done_seen); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL rmw_state: got %0d expected 0", dbg_state); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_routing();
        test_zero_len();
        test_busy_hold();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
